// File: rtl/pass_entry.sv
// Password-entry front end: synchronizes and debounces a 2-bit keypad, collects two
// digits for the gate FSM, waits for its verdict and locks out after repeated denials.
module pass_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int MAX_TRIES       = 3,
  parameter int LOCK_CYCLES     = 128
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_press,
  input  logic [1:0] key_code,
  input  logic       key_clear,
  input  logic       grant,
  input  logic       deny,
  output logic [1:0] pass1,
  output logic [1:0] pass2,
  output logic       pass_valid,
  output logic [1:0] digit_cnt,
  output logic       locked,
  output logic [1:0] tries
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LKW = $clog2(LOCK_CYCLES + 1);
  localparam logic [DBW-1:0] DEB_MAX   = DBW'(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] DEB_PRE   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [LKW-1:0] LK_LAST   = LKW'(LOCK_CYCLES - 1);
  localparam logic [1:0]     TRIES_MAX = 2'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_ONE_DIGIT = 2'd1,
    S_PRESENT   = 2'd2,
    S_LOCKED    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       press_sync_q, clear_sync_q;
  logic [1:0]       code_s1_q, code_s2_q;
  logic             grant_s_q, grant_d_q, deny_s_q, deny_d_q;
  logic [DBW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [TOW-1:0]   idle_q, idle_d;
  logic [LKW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [1:0]       pass1_q, pass1_d, pass2_q, pass2_d, digit_cnt_q, digit_cnt_d;
  logic [1:0]       tries_q, tries_d;
  logic             pass_valid_q, pass_valid_d, locked_q, locked_d;

  logic             press_s, clear_s, accept_s, grant_edge_s, deny_edge_s, to_empty_s;
  logic [1:0]       tries_inc_s;

  assign press_s      = press_sync_q[1];
  assign clear_s      = clear_sync_q[1];
  // Only the 3->4 step accepts, so a saturated (held) key never repeats.
  assign accept_s     = press_s && (deb_cnt_q == DEB_PRE);
  assign grant_edge_s = grant_s_q & ~grant_d_q;
  assign deny_edge_s  = deny_s_q & ~deny_d_q;
  assign tries_inc_s  = (tries_q == TRIES_MAX) ? tries_q : tries_q + 2'd1;

  // Debounce counter next value.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    if (!press_s) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_MAX) begin
      deb_cnt_d = deb_cnt_q + DBW'(1);
    end else begin
      deb_cnt_d = deb_cnt_q;
    end
  end

  // Entry FSM next state and registered output values.
  always_comb begin
    state_d      = state_q;
    pass1_d      = pass1_q;
    pass2_d      = pass2_q;
    pass_valid_d = pass_valid_q;
    digit_cnt_d  = digit_cnt_q;
    locked_d     = locked_q;
    tries_d      = tries_q;
    idle_d       = idle_q;
    lock_cnt_d   = lock_cnt_q;
    to_empty_s   = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept_s) begin
          pass1_d     = code_s2_q;
          digit_cnt_d = 2'd1;
          idle_d      = '0;
          state_d     = S_ONE_DIGIT;
        end else begin
          idle_d = '0;
        end
      end
      S_ONE_DIGIT: begin
        if (clear_s) begin
          to_empty_s = 1'b1;
        end else if (grant_edge_s || deny_edge_s) begin
          idle_d = '0;
        end else if (idle_q == TO_LAST) begin
          to_empty_s = 1'b1;
        end else if (accept_s) begin
          pass2_d      = code_s2_q;
          digit_cnt_d  = 2'd2;
          pass_valid_d = 1'b1;
          idle_d       = '0;
          state_d      = S_PRESENT;
        end else begin
          idle_d = idle_q + TOW'(1);
        end
      end
      S_PRESENT: begin
        if (clear_s) begin
          to_empty_s = 1'b1;
        end else if (grant_edge_s) begin
          tries_d    = 2'd0;
          to_empty_s = 1'b1;
        end else if (deny_edge_s) begin
          tries_d = tries_inc_s;
          if (tries_inc_s == TRIES_MAX) begin
            state_d      = S_LOCKED;
            locked_d     = 1'b1;
            lock_cnt_d   = '0;
            pass1_d      = 2'd0;
            pass2_d      = 2'd0;
            pass_valid_d = 1'b0;
            digit_cnt_d  = 2'd0;
          end else begin
            to_empty_s = 1'b1;
          end
        end else if (idle_q == TO_LAST) begin
          to_empty_s = 1'b1;
        end else begin
          idle_d = idle_q + TOW'(1);
        end
      end
      S_LOCKED: begin
        if (lock_cnt_q == LK_LAST) begin
          tries_d    = 2'd0;
          locked_d   = 1'b0;
          to_empty_s = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + LKW'(1);
        end
      end
      default: begin
        locked_d   = 1'b0;
        to_empty_s = 1'b1;
      end
    endcase
    if (to_empty_s) begin
      state_d      = S_EMPTY;
      pass1_d      = 2'd0;
      pass2_d      = 2'd0;
      pass_valid_d = 1'b0;
      digit_cnt_d  = 2'd0;
      idle_d       = '0;
    end else begin
      idle_d = idle_d;
    end
  end

  // Synchronizers, verdict edge registers and all state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_sync_q <= 2'b00;
      clear_sync_q <= 2'b00;
      code_s1_q    <= 2'd0;
      code_s2_q    <= 2'd0;
      grant_s_q    <= 1'b0;
      grant_d_q    <= 1'b0;
      deny_s_q     <= 1'b0;
      deny_d_q     <= 1'b0;
      deb_cnt_q    <= '0;
      idle_q       <= '0;
      lock_cnt_q   <= '0;
      state_q      <= S_EMPTY;
      pass1_q      <= 2'd0;
      pass2_q      <= 2'd0;
      pass_valid_q <= 1'b0;
      digit_cnt_q  <= 2'd0;
      locked_q     <= 1'b0;
      tries_q      <= 2'd0;
    end else begin
      press_sync_q <= {press_sync_q[0], key_press};
      clear_sync_q <= {clear_sync_q[0], key_clear};
      code_s1_q    <= key_code;
      code_s2_q    <= code_s1_q;
      grant_s_q    <= grant;
      grant_d_q    <= grant_s_q;
      deny_s_q     <= deny;
      deny_d_q     <= deny_s_q;
      deb_cnt_q    <= deb_cnt_d;
      idle_q       <= idle_d;
      lock_cnt_q   <= lock_cnt_d;
      state_q      <= state_d;
      pass1_q      <= pass1_d;
      pass2_q      <= pass2_d;
      pass_valid_q <= pass_valid_d;
      digit_cnt_q  <= digit_cnt_d;
      locked_q     <= locked_d;
      tries_q      <= tries_d;
    end
  end

  assign pass1      = pass1_q;
  assign pass2      = pass2_q;
  assign pass_valid = pass_valid_q;
  assign digit_cnt  = digit_cnt_q;
  assign locked     = locked_q;
  assign tries      = tries_q;

endmodule
